mem_port_arbiter: RTL

Shares one single-ported, fixed-latency memory between the core's instruction-fetch requester (imem, read-only) and data requester (dmem, read/write). It sits between the core's `mem_if` driver ports and a unified memory, and generates the per-requester `hit` that is otherwise tied high. Data accesses have priority over fetches, with a bounded-starvation guarantee for fetches. The block is sequenced by a small issue/response state machine.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_perf.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for mem_port_arbiter: FSM states, requester ids, streak width.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RESP_I = 2'd1,
      RESP_D = 2'd2
   } state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

   localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating grant / fetch-wait counters for mem_port_arbiter.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf (
   input  logic        clk,
   input  logic        reset,
   input  logic        imem_grant,
   input  logic        dmem_grant,
   input  logic        imem_wait,
   output logic [31:0] perf_imem_grants,
   output logic [31:0] perf_dmem_grants,
   output logic [31:0] perf_imem_wait
);

   logic [31:0] r_imem_grants;
   logic [31:0] r_dmem_grants;
   logic [31:0] r_imem_wait;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      if (v == 32'hFFFF_FFFF) begin
         return v;
      end else begin
         return v + 32'd1;
      end
   endfunction

   // counter registers, each holding at all-ones once saturated
   always_ff @(posedge clk) begin
      if (reset) begin
         r_imem_grants <= 32'd0;
         r_dmem_grants <= 32'd0;
         r_imem_wait   <= 32'd0;
      end else begin
         if (imem_grant) r_imem_grants <= sat_inc(r_imem_grants);
         if (dmem_grant) r_dmem_grants <= sat_inc(r_dmem_grants);
         if (imem_wait)  r_imem_wait   <= sat_inc(r_imem_wait);
      end
   end

   assign perf_imem_grants = r_imem_grants;
   assign perf_dmem_grants = r_dmem_grants;
   assign perf_imem_wait   = r_imem_wait;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between fetch (imem) and
// data (dmem) requesters. Optional perf counters: define MEM_ARB_PERF_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] imem_addr,
   input  logic        imem_read_en,
   output logic [31:0] imem_data_o,
   output logic        imem_hit,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_data_i,
   input  logic [3:0]  dmem_data_en,
   input  logic        dmem_read_en,
   input  logic        dmem_write_en,
   output logic [31:0] dmem_data_o,
   output logic        dmem_hit,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_i,
   output logic [3:0]  mem_data_en,
   output logic        mem_read_en,
   output logic        mem_write_en,
   input  logic [31:0] mem_data_o,
   output logic [31:0] perf_imem_grants,
   output logic [31:0] perf_dmem_grants,
   output logic [31:0] perf_imem_wait
);

   localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [STREAK_W-1:0]   r_streak;
   logic [STREAK_W-1:0]   w_streak_nxt;
   logic                  r_is_write;
   logic                  w_grant_valid;
   req_id_t               w_grant_id;
   logic                  w_dmem_req;

   assign w_dmem_req = dmem_read_en | dmem_write_en;

   // grant decision, downstream mux and response outputs
   always_comb begin
      w_state_nxt   = r_state;
      w_grant_valid = 1'b0;
      w_grant_id    = REQ_D;
      mem_addr      = 32'd0;
      mem_data_i    = 32'd0;
      mem_data_en   = 4'd0;
      mem_read_en   = 1'b0;
      mem_write_en  = 1'b0;
      imem_hit      = 1'b0;
      imem_data_o   = 32'd0;
      dmem_hit      = 1'b0;
      dmem_data_o   = 32'd0;
      case (r_state)
         IDLE: begin
            // dmem wins unless a waiting fetch has hit the starvation bound
            if (reset) begin
               w_state_nxt = IDLE;
            end else if (w_dmem_req && !(imem_read_en && (r_streak == LIMIT))) begin
               w_grant_valid = 1'b1;
               w_grant_id    = REQ_D;
               mem_addr      = dmem_addr;
               mem_data_i    = dmem_data_i;
               mem_data_en   = dmem_data_en;
               mem_write_en  = dmem_write_en;
               mem_read_en   = ~dmem_write_en;
               w_state_nxt   = RESP_D;
            end else if (imem_read_en) begin
               w_grant_valid = 1'b1;
               w_grant_id    = REQ_I;
               mem_addr      = imem_addr;
               mem_data_en   = 4'hF;
               mem_read_en   = 1'b1;
               w_state_nxt   = RESP_I;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RESP_I: begin
            imem_hit    = ~reset;
            imem_data_o = reset ? 32'd0 : mem_data_o;
            w_state_nxt = IDLE;
         end
         RESP_D: begin
            dmem_hit    = ~reset;
            dmem_data_o = (reset || r_is_write) ? 32'd0 : mem_data_o;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // starvation streak next value
   always_comb begin
      w_streak_nxt = r_streak;
      if (!imem_read_en) begin
         w_streak_nxt = {STREAK_W{1'b0}};
      end else if (w_grant_valid && (w_grant_id == REQ_I)) begin
         w_streak_nxt = {STREAK_W{1'b0}};
      end else if (w_grant_valid && (r_streak < LIMIT)) begin
         w_streak_nxt = r_streak + {{(STREAK_W-1){1'b0}}, 1'b1};
      end else begin
         w_streak_nxt = r_streak;
      end
   end

   // state, streak and registered dmem access type
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_streak   <= {STREAK_W{1'b0}};
         r_is_write <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_streak <= w_streak_nxt;
         if (w_grant_valid && (w_grant_id == REQ_D)) begin
            r_is_write <= dmem_write_en;
         end
      end
   end

`ifdef MEM_ARB_PERF_EN
   logic w_imem_issue;
   logic w_dmem_issue;
   logic w_imem_wait;

   assign w_imem_issue = w_grant_valid && (w_grant_id == REQ_I);
   assign w_dmem_issue = w_grant_valid && (w_grant_id == REQ_D);
   // a fetch already in its response cycle is not waiting
   assign w_imem_wait  = imem_read_en && !w_imem_issue && (r_state != RESP_I) && !reset;

   mem_arb_perf u_perf (
      .clk              (clk),
      .reset            (reset),
      .imem_grant       (w_imem_issue),
      .dmem_grant       (w_dmem_issue),
      .imem_wait        (w_imem_wait),
      .perf_imem_grants (perf_imem_grants),
      .perf_dmem_grants (perf_dmem_grants),
      .perf_imem_wait   (perf_imem_wait)
   );
`else
   assign perf_imem_grants = 32'd0;
   assign perf_dmem_grants = 32'd0;
   assign perf_imem_wait   = 32'd0;
`endif

endmodule
